// File: rtl/cache_mem_ctrl.sv
// Block-transfer sequencer between the cache miss/evict path and a word-wide memory bus:
// optional 16-word victim write-back, then a 16-word refill returned to the cache as one block.
module cache_mem_ctrl #(
    parameter int PA_WIDTH  = 32,
    parameter int WRD_WIDTH = 32,
    parameter int BLK_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wb,
    input  logic [PA_WIDTH-1:0]  req_wb_addr,
    input  logic [BLK_WIDTH-1:0] req_wb_blk,
    input  logic [PA_WIDTH-1:0]  req_rd_addr,
    output logic                 resp_valid,
    output logic [BLK_WIDTH-1:0] resp_blk,
    output logic                 busy,
    output logic                 mem_cmd_valid,
    input  logic                 mem_cmd_ready,
    output logic                 mem_cmd_we,
    output logic [PA_WIDTH-1:0]  mem_cmd_addr,
    output logic [WRD_WIDTH-1:0] mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [WRD_WIDTH-1:0] mem_rdata
);
    localparam int WPB   = BLK_WIDTH / WRD_WIDTH;
    localparam int IW    = $clog2(WPB);
    localparam int CW    = IW + 1;
    localparam int BYTEW = $clog2(WRD_WIDTH / 8);
    localparam int OFS   = IW + BYTEW;
    localparam logic [CW-1:0] LAST = CW'(WPB - 1);
    localparam logic [CW-1:0] FULL = CW'(WPB);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_DONE} state_t;

    state_t                        state;
    logic [CW-1:0]                 cmd_cnt, beat_cnt, cmd_nxt;
    logic [PA_WIDTH-1:0]           wb_addr_q, rd_addr_q;
    logic [WPB-1:0][WRD_WIDTH-1:0] wb_words, rd_words;
    logic                          unused_ofs;

    function automatic logic [PA_WIDTH-1:0] word_addr(input logic [PA_WIDTH-1:0] base,
                                                      input logic [CW-1:0] idx);
        return {base[PA_WIDTH-1:OFS], idx[IW-1:0], {BYTEW{1'b0}}};
    endfunction

    assign req_ready  = (state == S_IDLE);
    assign resp_blk   = rd_words;
    assign cmd_nxt    = cmd_cnt + CW'(1);
    // block-offset bits of the request addresses are dropped by word_addr()
    assign unused_ofs = ^{wb_addr_q[OFS-1:0], rd_addr_q[OFS-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cmd_cnt       <= '0;
            beat_cnt      <= '0;
            wb_addr_q     <= '0;
            rd_addr_q     <= '0;
            wb_words      <= '0;
            rd_words      <= '0;
            resp_valid    <= 1'b0;
            busy          <= 1'b0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_wdata     <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wb_addr_q     <= req_wb_addr;
                        rd_addr_q     <= req_rd_addr;
                        wb_words      <= req_wb_blk;
                        cmd_cnt       <= '0;
                        beat_cnt      <= '0;
                        busy          <= 1'b1;
                        mem_cmd_valid <= 1'b1;
                        if (req_wb) begin
                            state        <= S_WB;
                            mem_cmd_we   <= 1'b1;
                            mem_cmd_addr <= word_addr(req_wb_addr, '0);
                            mem_wdata    <= req_wb_blk[WRD_WIDTH-1:0];
                        end else begin
                            state        <= S_RD;
                            mem_cmd_we   <= 1'b0;
                            mem_cmd_addr <= word_addr(req_rd_addr, '0);
                        end
                    end
                end
                S_WB: begin
                    if (mem_cmd_ready) begin
                        if (cmd_cnt == LAST) begin
                            // first read goes out on the same edge the last write is taken
                            cmd_cnt      <= '0;
                            state        <= S_RD;
                            mem_cmd_we   <= 1'b0;
                            mem_cmd_addr <= word_addr(rd_addr_q, '0);
                        end else begin
                            cmd_cnt      <= cmd_nxt;
                            mem_cmd_addr <= word_addr(wb_addr_q, cmd_nxt);
                            mem_wdata    <= wb_words[cmd_nxt[IW-1:0]];
                        end
                    end
                end
                S_RD: begin
                    if (mem_cmd_valid && mem_cmd_ready) begin
                        cmd_cnt <= cmd_nxt;
                        if (cmd_nxt == FULL) mem_cmd_valid <= 1'b0;
                        else                 mem_cmd_addr  <= word_addr(rd_addr_q, cmd_nxt);
                    end
                    // beats run concurrently with commands; anything past the 16th is dropped
                    if (mem_rvalid && beat_cnt != FULL) begin
                        rd_words[beat_cnt[IW-1:0]] <= mem_rdata;
                        beat_cnt                   <= beat_cnt + CW'(1);
                        if (beat_cnt == LAST) begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    cmd_cnt  <= '0;
                    beat_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: behavioural word memory with latency/back-pressure, expected
// command streams and refill blocks derived from block/word address arithmetic.
module tb_cache_mem_ctrl;
    localparam int PA = 32, WW = 32, BW = 512, WPB = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid, req_ready, req_wb;
    logic [PA-1:0] req_wb_addr, req_rd_addr;
    logic [BW-1:0] req_wb_blk, resp_blk;
    logic resp_valid, busy;
    logic mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_rvalid;
    logic [PA-1:0] mem_cmd_addr;
    logic [WW-1:0] mem_wdata, mem_rdata;

    cache_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_wb_addr(req_wb_addr), .req_wb_blk(req_wb_blk), .req_rd_addr(req_rd_addr),
        .resp_valid(resp_valid), .resp_blk(resp_blk), .busy(busy),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vec = 0, errs = 0;
    int tick = 0;
    int rdy_mode = 0, lat = 1, stray_n = 0, stall_viol = 0, stall_seen = 0;
    bit extra_beat = 0;
    logic [31:0] mem [bit [31:0]];
    logic log_we[$];
    logic [31:0] log_addr[$], log_data[$];
    int pend_due[$];
    logic [31:0] pend_data[$];
    bit prev_stall = 0;
    logic [31:0] st_addr, st_data;
    logic st_we;
    logic [BW-1:0] t1_blk;

    // one clock of the memory model, acting at the falling edge
    task automatic step();
        bit rdy;
        logic [31:0] a;
        @(negedge clk);
        tick++;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (tick % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        mem_cmd_ready = rdy;
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall && (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== st_addr ||
                mem_cmd_we !== st_we || (st_we && mem_wdata !== st_data))) stall_viol++;
            prev_stall = (mem_cmd_valid === 1'b1) && !rdy;
            if (prev_stall) stall_seen++;
            st_addr = mem_cmd_addr; st_we = mem_cmd_we; st_data = mem_wdata;
            if (mem_cmd_valid === 1'b1 && rdy) begin
                a = mem_cmd_addr;
                log_we.push_back(mem_cmd_we); log_addr.push_back(a); log_data.push_back(mem_wdata);
                if (mem_cmd_we) mem[a] = mem_wdata;
                else begin
                    pend_due.push_back(tick + lat);
                    pend_data.push_back(mem.exists(a) ? mem[a] : a);
                end
            end
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (pend_due.size() > 0 && pend_due[0] == tick) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_data.pop_front();
            void'(pend_due.pop_front());
            if (extra_beat && pend_due.size() == 0) begin
                pend_due.push_back(tick + 1); pend_data.push_back($urandom); extra_beat = 0;
            end
        end else if (stray_n > 0) begin
            mem_rvalid = 1'b1;
            stray_n--;
        end
    endtask

    // refill block the memory should return, computed before the transfer starts
    function automatic logic [BW-1:0] exp_blk(bit wb, logic [31:0] wa, logic [BW-1:0] wblk,
                                             logic [31:0] ra);
        logic [BW-1:0] r;
        logic [31:0] a, v;
        for (int i = 0; i < WPB; i++) begin
            a = (ra & 32'hFFFF_FFC0) + 32'(4 * i);
            v = mem.exists(a) ? mem[a] : a;
            if (wb && (a & 32'hFFFF_FFC0) == (wa & 32'hFFFF_FFC0)) v = wblk[i*32 +: 32];
            r[i*32 +: 32] = v;
        end
        return r;
    endfunction

    // number of logged commands that differ from the ideal write-then-read stream
    function automatic int cmd_errs(bit wb, logic [31:0] wa, logic [BW-1:0] wblk, logic [31:0] ra);
        logic e_we[$];
        logic [31:0] e_a[$], e_d[$];
        int bad = 0, n;
        if (wb) for (int i = 0; i < WPB; i++) begin
            e_we.push_back(1'b1); e_a.push_back((wa & 32'hFFFF_FFC0) + 32'(4 * i));
            e_d.push_back(wblk[i*32 +: 32]);
        end
        for (int i = 0; i < WPB; i++) begin
            e_we.push_back(1'b0); e_a.push_back((ra & 32'hFFFF_FFC0) + 32'(4 * i)); e_d.push_back('0);
        end
        n = (e_we.size() < log_we.size()) ? e_we.size() : log_we.size();
        bad = (e_we.size() > log_we.size()) ? e_we.size() - log_we.size() : log_we.size() - e_we.size();
        for (int i = 0; i < n; i++)
            if (log_we[i] !== e_we[i] || log_addr[i] !== e_a[i] || (e_we[i] && log_data[i] !== e_d[i]))
                bad++;
        return bad;
    endfunction

    task automatic rand_blk(output logic [BW-1:0] b);
        for (int i = 0; i < WPB; i++) b[i*32 +: 32] = $urandom;
    endtask

    task automatic do_xfer(input bit wb, input logic [31:0] wa, input logic [BW-1:0] wblk,
                           input logic [31:0] ra, output logic [BW-1:0] got, output int latency,
                           output bit timeout, output int pulse_w, output bit hs_ok);
        int t0;
        logic [BW-1:0] junk;
        log_we.delete(); log_addr.delete(); log_data.delete();
        step();
        hs_ok = (req_ready === 1'b1);
        req_valid = 1'b1; req_wb = wb; req_wb_addr = wa; req_wb_blk = wblk; req_rd_addr = ra;
        t0 = tick;
        step();
        rand_blk(junk);
        req_valid = 1'b0; req_wb = ~wb; req_wb_addr = $urandom; req_rd_addr = $urandom; req_wb_blk = junk;
        hs_ok &= (busy === 1'b1) && (req_ready === 1'b0);
        timeout = 1; got = '0; latency = -1; pulse_w = 0;
        for (int n = 0; n < 3000; n++) begin
            hs_ok &= (busy === 1'b1);
            if (resp_valid === 1'b1) begin
                timeout = 0; got = resp_blk; latency = tick - t0;
                break;
            end
            step();
        end
        while (!timeout && resp_valid === 1'b1 && pulse_w < 4) begin
            pulse_w++;
            step();
        end
        if (!timeout) hs_ok &= (busy === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        req_valid = 0; req_wb = 0; req_wb_addr = '0; req_rd_addr = '0; req_wb_blk = '0;
        mem_cmd_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        rst_n = 0;
        repeat (3) step();
        vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vec++; if (mem_cmd_valid !== 1'b0 || mem_cmd_we !== 1'b0) begin errs++;
            $display("FAIL reset_cmd got valid=%b we=%b exp 0/0", mem_cmd_valid, mem_cmd_we); end
        vec++; if (mem_cmd_addr !== '0 || mem_wdata !== '0) begin errs++;
            $display("FAIL reset_fields got addr=%h wdata=%h exp 0", mem_cmd_addr, mem_wdata); end
        vec++; if (resp_blk !== '0) begin errs++; $display("FAIL reset_resp_blk got=%h exp=0", resp_blk); end
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        rst_n = 1;
        step();
    endtask

    task automatic test_clean_miss();
        logic [BW-1:0] got, exp;
        int latency, pw;
        bit to, hs;
        exp = exp_blk(0, '0, '0, 32'h0000_1240);
        do_xfer(0, '0, '0, 32'h0000_1240, got, latency, to, pw, hs);
        t1_blk = got;
        vec++; if (to) begin errs++; $display("FAIL clean_timeout no resp_valid within budget"); end
        vec++; if (got !== exp) begin errs++; $display("FAIL clean_blk got=%h exp=%h", got, exp); end
        vec++; if (latency != 18) begin errs++; $display("FAIL clean_latency got=%0d exp=18", latency); end
        vec++; if (pw != 1) begin errs++; $display("FAIL clean_pulse got=%0d cycles exp=1", pw); end
        vec++; if (cmd_errs(0, '0, '0, 32'h0000_1240) != 0) begin errs++;
            $display("FAIL clean_cmds got=%0d bad commands exp=0", cmd_errs(0, '0, '0, 32'h0000_1240)); end
        vec++; if (!hs) begin errs++; $display("FAIL clean_handshake got=0 exp=1 (ready/busy sequence)"); end
    endtask

    task automatic test_dirty_miss();
        logic [BW-1:0] got, exp, wblk;
        int latency, pw, nb;
        bit to, hs;
        for (int i = 0; i < WPB; i++) wblk[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
        exp = exp_blk(1, 32'h0000_8000, wblk, 32'h0000_3000);
        do_xfer(1, 32'h0000_8000, wblk, 32'h0000_3000, got, latency, to, pw, hs);
        nb = cmd_errs(1, 32'h0000_8000, wblk, 32'h0000_3000);
        vec++; if (to) begin errs++; $display("FAIL dirty_timeout no resp_valid within budget"); end
        vec++; if (nb != 0) begin errs++; $display("FAIL dirty_cmds got=%0d bad commands exp=0", nb); end
        vec++; if (got !== exp) begin errs++; $display("FAIL dirty_blk got=%h exp=%h", got, exp); end
        vec++; if (latency != 34) begin errs++; $display("FAIL dirty_latency got=%0d exp=34", latency); end
        vec++; if (pw != 1 || !hs) begin errs++; $display("FAIL dirty_pulse got=%0d/%0d exp=1/1", pw, hs); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] got;
        int latency, pw, nb;
        bit to, hs;
        rdy_mode = 1; lat = 5; stall_viol = 0; stall_seen = 0;
        do_xfer(0, '0, '0, 32'h0000_1240, got, latency, to, pw, hs);
        nb = cmd_errs(0, '0, '0, 32'h0000_1240);
        vec++; if (to) begin errs++; $display("FAIL bp_timeout no resp_valid within budget"); end
        vec++; if (got !== t1_blk) begin errs++; $display("FAIL bp_blk got=%h exp=%h", got, t1_blk); end
        vec++; if (stall_viol != 0 || stall_seen == 0) begin errs++;
            $display("FAIL bp_stall_stable got=%0d violations (%0d stalls) exp=0", stall_viol, stall_seen); end
        vec++; if (nb != 0 || pw != 1) begin errs++; $display("FAIL bp_cmds got=%0d bad pulse=%0d exp=0/1", nb, pw); end
        rdy_mode = 0; lat = 1;
    endtask

    task automatic test_reset_mid_wb();
        logic [BW-1:0] wblk, got, exp;
        int latency, pw, nb;
        bit to, hs;
        rand_blk(wblk);
        log_we.delete(); log_addr.delete(); log_data.delete();
        step();
        req_valid = 1; req_wb = 1; req_wb_addr = 32'h0000_5000; req_wb_blk = wblk; req_rd_addr = 32'h0000_6000;
        step();
        req_valid = 0;
        for (int n = 0; n < 200 && log_we.size() < 7; n++) step();
        @(posedge clk); #1;
        rst_n = 0;
        pend_due.delete(); pend_data.delete();
        #1;
        vec++; if (mem_cmd_valid !== 1'b0 || busy !== 1'b0 || mem_cmd_addr !== '0 || mem_wdata !== '0 ||
                  mem_cmd_we !== 1'b0 || req_ready !== 1'b1) begin errs++;
            $display("FAIL midwb_reset got valid=%b busy=%b addr=%h wdata=%h we=%b rdy=%b exp 0/0/0/0/0/1",
                     mem_cmd_valid, busy, mem_cmd_addr, mem_wdata, mem_cmd_we, req_ready); end
        stray_n = 2;
        repeat (2) step();
        rst_n = 1;
        stray_n = 3;
        repeat (4) step();
        vec++; if (resp_blk !== '0 || busy !== 1'b0 || mem_cmd_valid !== 1'b0 || resp_valid !== 1'b0) begin errs++;
            $display("FAIL midwb_stray got blk=%h busy=%b cmdv=%b respv=%b exp 0", resp_blk, busy, mem_cmd_valid, resp_valid); end
        rand_blk(wblk);
        exp = exp_blk(1, 32'h0000_5000, wblk, 32'h0000_6000);
        do_xfer(1, 32'h0000_5000, wblk, 32'h0000_6000, got, latency, to, pw, hs);
        nb = cmd_errs(1, 32'h0000_5000, wblk, 32'h0000_6000);
        vec++; if (nb != 0 || to) begin errs++; $display("FAIL midwb_restart got=%0d bad commands timeout=%0d exp=0/0", nb, to); end
        vec++; if (got !== exp) begin errs++; $display("FAIL midwb_blk got=%h exp=%h", got, exp); end
    endtask

    task automatic test_spurious();
        logic [BW-1:0] keep, got, exp;
        int latency, pw;
        bit to, hs;
        keep = resp_blk;
        stray_n = 4;
        repeat (5) step();
        vec++; if (resp_blk !== keep || busy !== 1'b0 || mem_cmd_valid !== 1'b0 || req_ready !== 1'b1) begin errs++;
            $display("FAIL idle_rvalid got blk=%h busy=%b cmdv=%b exp blk=%h idle", resp_blk, busy, mem_cmd_valid, keep); end
        extra_beat = 1;
        exp = exp_blk(0, '0, '0, 32'h0000_7A00);
        do_xfer(0, '0, '0, 32'h0000_7A00, got, latency, to, pw, hs);
        repeat (2) step();
        vec++; if (got !== exp || resp_blk !== exp) begin errs++;
            $display("FAIL beat17 got resp=%h now=%h exp=%h", got, resp_blk, exp); end
        vec++; if (to || !hs || busy !== 1'b0 || req_ready !== 1'b1) begin errs++;
            $display("FAIL beat17_state got busy=%b ready=%b hs=%0d exp 0/1/1", busy, req_ready, hs); end
        extra_beat = 0;
    endtask

    task automatic test_same_addr();
        logic [BW-1:0] wblk, got;
        int latency, pw, nb;
        bit to, hs;
        rand_blk(wblk);
        do_xfer(1, 32'h0000_2000, wblk, 32'h0000_2000, got, latency, to, pw, hs);
        nb = cmd_errs(1, 32'h0000_2000, wblk, 32'h0000_2000);
        vec++; if (got !== wblk || to) begin errs++; $display("FAIL same_addr_blk got=%h exp=%h", got, wblk); end
        vec++; if (nb != 0) begin errs++; $display("FAIL same_addr_cmds got=%0d bad commands exp=0", nb); end
    endtask

    task automatic test_random();
        logic [BW-1:0] wblk, got, exp;
        logic [31:0] wa, ra;
        int latency, pw, nb;
        bit to, hs, wb;
        for (int k = 0; k < 8; k++) begin
            wb = 1'($urandom_range(0, 1)); wa = $urandom; ra = (k == 3) ? wa : $urandom;
            rand_blk(wblk);
            rdy_mode = $urandom_range(0, 2); lat = $urandom_range(1, 4); stall_viol = 0;
            exp = exp_blk(wb, wa, wblk, ra);
            do_xfer(wb, wa, wblk, ra, got, latency, to, pw, hs);
            nb = cmd_errs(wb, wa, wblk, ra);
            vec++; if (got !== exp || to) begin errs++; $display("FAIL rand%0d_blk got=%h exp=%h", k, got, exp); end
            vec++; if (nb != 0 || stall_viol != 0 || pw != 1 || !hs) begin errs++;
                $display("FAIL rand%0d_proto got bad=%0d stall=%0d pulse=%0d hs=%0d exp 0/0/1/1", k, nb, stall_viol, pw, hs); end
        end
        rdy_mode = 0; lat = 1;
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_reset_mid_wb();
        test_spurious();
        test_same_addr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
